// File: rtl/rtc_hms_cfg.sv
// rtc_hms_cfg: prescaled 24-hour BCD clock with validated set, alarm and 12/24-hour display
module rtc_hms_cfg #(
  parameter int TICK_DIV = 50000000,
  parameter int ALARM_EN = 1
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode_24,
  input  logic       set_stb,
  input  logic [5:0] set_hr,
  input  logic [6:0] set_min,
  input  logic [6:0] set_sec,
  output logic       set_err,
  input  logic       alm_we,
  input  logic [5:0] alm_hr,
  input  logic [6:0] alm_min,
  input  logic       alm_arm,
  output logic [6:0] sec_bcd,
  output logic [6:0] min_bcd,
  output logic [5:0] hr_bcd,
  output logic       pm,
  output logic       tick,
  output logic       tc,
  output logic       alarm_hit
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  function automatic logic ms_ok(input logic [6:0] v);
    return v[3:0] <= 4'd9 && v[6:4] <= 3'd5;
  endfunction

  function automatic logic hr_ok(input logic [5:0] v);
    return v[3:0] <= 4'd9 && v <= 6'h23;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] sec_q, sec_d, min_q, min_d, sec_inc, min_inc;
  logic [5:0] hr_q, hr_d, hr_inc, hr_pm;
  logic tick_q, tick_d, tc_q, tc_d, err_q, err_d;
  logic set_ok, pre_wrap, sec_wrap, min_wrap, hr_wrap;

  always_comb begin
    sec_wrap = sec_q == 7'h59;
    min_wrap = min_q == 7'h59;
    hr_wrap  = hr_q == 6'h23;
    sec_inc  = sec_q[3:0] == 4'd9 ? {sec_q[6:4] + 3'd1, 4'd0} : {sec_q[6:4], sec_q[3:0] + 4'd1};
    min_inc  = min_q[3:0] == 4'd9 ? {min_q[6:4] + 3'd1, 4'd0} : {min_q[6:4], min_q[3:0] + 4'd1};
    hr_inc   = hr_q[3:0] == 4'd9 ? {hr_q[5:4] + 2'd1, 4'd0} : {hr_q[5:4], hr_q[3:0] + 4'd1};
    set_ok   = set_stb && hr_ok(set_hr) && ms_ok(set_min) && ms_ok(set_sec);
    pre_wrap = en && cnt_q == LAST;
    tick_d   = pre_wrap && !set_ok;
    cnt_d    = set_ok || pre_wrap ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    sec_d    = set_ok ? set_sec : tick_d ? (sec_wrap ? 7'h00 : sec_inc) : sec_q;
    min_d    = set_ok ? set_min : tick_d && sec_wrap ? (min_wrap ? 7'h00 : min_inc) : min_q;
    hr_d     = set_ok ? set_hr : tick_d && sec_wrap && min_wrap ? (hr_wrap ? 6'h00 : hr_inc) : hr_q;
    tc_d     = tick_d && sec_wrap && min_wrap && hr_wrap;
    err_d    = set_stb && !set_ok;
  end

  always_ff @(posedge clk_50) begin
    if (rst_n) begin
      cnt_q  <= '0;
      sec_q  <= 7'h00;
      min_q  <= 7'h00;
      hr_q   <= 6'h00;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hr_q   <= hr_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
      err_q  <= err_d;
    end
  end

  generate
    if (ALARM_EN != 0) begin : g_alarm
      logic [5:0] ahr_q;
      logic [6:0] amin_q;
      logic ahit_q, ahit_d;
      assign ahit_d = alm_arm && (set_ok || tick_d) && hr_d == ahr_q && min_d == amin_q && sec_d == 7'h00;
      always_ff @(posedge clk_50) begin
        if (rst_n) begin
          ahr_q  <= 6'h00;
          amin_q <= 7'h00;
          ahit_q <= 1'b0;
        end else begin
          if (alm_we && hr_ok(alm_hr) && ms_ok(alm_min)) begin
            ahr_q  <= alm_hr;
            amin_q <= alm_min;
          end
          ahit_q <= ahit_d;
        end
      end
      assign alarm_hit = ahit_q;
    end else begin : g_no_alarm
      assign alarm_hit = 1'b0;
    end
  endgenerate

  assign hr_pm   = hr_q[5:4] == 2'd1 ? {2'd0, hr_q[3:0] - 4'd2} :
                   hr_q[3:0] < 4'd2 ? {2'd0, hr_q[3:0] + 4'd8} : {2'd1, hr_q[3:0] - 4'd2};
  assign hr_bcd  = mode_24 ? hr_q : (hr_q == 6'h00 || hr_q == 6'h12) ? 6'h12 : hr_q > 6'h12 ? hr_pm : hr_q;
  assign pm      = !mode_24 && hr_q >= 6'h12;
  assign sec_bcd = sec_q;
  assign min_bcd = min_q;
  assign tick    = tick_q;
  assign tc      = tc_q;
  assign set_err = err_q;
endmodule

// File: tb/tb_rtc_hms_cfg.sv
// tb_rtc_hms_cfg: directed vectors for rtc_hms_cfg with TICK_DIV=4 and a TICK_DIV=1 instance
module tb_rtc_hms_cfg;
  logic clk_50 = 1'b0, rst_n = 1'b1, en = 1'b0, mode_24 = 1'b0, set_stb = 1'b0;
  logic [5:0] set_hr = 6'h10, alm_hr = 6'h00, hr_bcd, hr1;
  logic [6:0] set_min = 7'h10, set_sec = 7'h10, alm_min = 7'h00, sec_bcd, min_bcd, sec1, min1;
  logic alm_we = 1'b0, alm_arm = 1'b0, en1 = 1'b0;
  logic set_err, pm, tick, tc, alarm_hit, err1, pm1, tick1, tc1, hit1;
  int nvec = 0, nerr = 0;

  logic [5:0] hin [8] = '{6'h00, 6'h11, 6'h12, 6'h13, 6'h23, 6'h19, 6'h20, 6'h22};
  logic [5:0] h12 [8] = '{6'h12, 6'h11, 6'h12, 6'h01, 6'h11, 6'h07, 6'h08, 6'h10};
  logic       pmx [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [5:0] bh [4]  = '{6'h24, 6'h10, 6'h10, 6'h1A};
  logic [6:0] bm [4]  = '{7'h00, 7'h60, 7'h0A, 7'h00};

  rtc_hms_cfg #(.TICK_DIV(4), .ALARM_EN(1)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .en(en), .mode_24(mode_24), .set_stb(set_stb),
    .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec), .set_err(set_err),
    .alm_we(alm_we), .alm_hr(alm_hr), .alm_min(alm_min), .alm_arm(alm_arm),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hr_bcd(hr_bcd), .pm(pm),
    .tick(tick), .tc(tc), .alarm_hit(alarm_hit)
  );

  rtc_hms_cfg #(.TICK_DIV(1), .ALARM_EN(1)) dut1 (
    .clk_50(clk_50), .rst_n(rst_n), .en(en1), .mode_24(1'b1), .set_stb(1'b0),
    .set_hr(6'h00), .set_min(7'h00), .set_sec(7'h00), .set_err(err1),
    .alm_we(1'b0), .alm_hr(6'h00), .alm_min(7'h00), .alm_arm(1'b0),
    .sec_bcd(sec1), .min_bcd(min1), .hr_bcd(hr1), .pm(pm1),
    .tick(tick1), .tc(tc1), .alarm_hit(hit1)
  );

  always #5 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic set_time(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
    set_hr = h; set_min = m; set_sec = s; set_stb = 1'b1;
    step();
    set_stb = 1'b0;
  endtask

  initial begin
    set_stb = 1'b1;
    step(3);
    set_stb = 1'b0;
    chk("rst_time", {hr_bcd, min_bcd, sec_bcd}, {6'h12, 7'h00, 7'h00});
    chk("rst_pm", pm, 0);
    chk("rst_pulses", {tick, tc, set_err, alarm_hit}, 4'b0000);
    rst_n = 1'b0;

    mode_24 = 1'b1; en = 1'b1;
    set_time(6'h23, 7'h59, 7'h58);
    chk("roll_load", {hr_bcd, min_bcd, sec_bcd}, {6'h23, 7'h59, 7'h58});
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("roll_tick", tick, (i % 4 == 0));
      chk("roll_tc", tc, (i == 8));
      if (i == 4) chk("roll_59", {hr_bcd, min_bcd, sec_bcd}, {6'h23, 7'h59, 7'h59});
      if (i == 8) chk("roll_00", {hr_bcd, min_bcd, sec_bcd}, {6'h00, 7'h00, 7'h00});
    end
    step();
    chk("roll_tc_off", tc, 0);
    set_time(6'h09, 7'h59, 7'h59);
    step(4);
    chk("carry_hr", {hr_bcd, min_bcd, sec_bcd, tc}, {6'h10, 7'h00, 7'h00, 1'b0});
    set_time(6'h10, 7'h19, 7'h59);
    step(4);
    chk("carry_min", {hr_bcd, min_bcd, sec_bcd}, {6'h10, 7'h20, 7'h00});

    en = 1'b0; mode_24 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_time(hin[i], 7'h30, 7'h15);
      chk("h12_hr", hr_bcd, h12[i]);
      chk("h12_pm", pm, pmx[i]);
      mode_24 = 1'b1;
      #1;
      chk("h24_hr", {pm, hr_bcd, min_bcd, sec_bcd}, {1'b0, hin[i], 7'h30, 7'h15});
      mode_24 = 1'b0;
    end

    mode_24 = 1'b1;
    set_time(6'h08, 7'h15, 7'h00);
    chk("set_ok_err", set_err, 0);
    for (int i = 0; i < 4; i++) begin
      set_time(bh[i], bm[i], 7'h00);
      chk("bad_err", set_err, 1);
      chk("bad_time", {hr_bcd, min_bcd, sec_bcd}, {6'h08, 7'h15, 7'h00});
      step();
      chk("bad_err_off", set_err, 0);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pre_tick", tick, 0);
    end
    set_time(6'h10, 7'h30, 7'h00);
    chk("coinc_drop", tick, 0);
    chk("coinc_time", {hr_bcd, min_bcd, sec_bcd}, {6'h10, 7'h30, 7'h00});
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("coinc_next", tick, (i == 4));
    end
    chk("coinc_sec", {hr_bcd, min_bcd, sec_bcd}, {6'h10, 7'h30, 7'h01});

    en = 1'b0;
    alm_hr = 6'h07; alm_min = 7'h00; alm_we = 1'b1;
    step();
    alm_we = 1'b0; alm_arm = 1'b1;
    set_time(6'h06, 7'h59, 7'h59);
    chk("alm_pre", alarm_hit, 0);
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("alm_hit", alarm_hit, (i == 4));
      if (i == 4) en = 1'b0;
    end
    chk("alm_time", {hr_bcd, min_bcd, sec_bcd}, {6'h07, 7'h00, 7'h00});
    for (int i = 0; i < 5; i++) begin
      step();
      chk("alm_norefire", alarm_hit, 0);
    end
    alm_arm = 1'b0;
    set_time(6'h06, 7'h59, 7'h59);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alm_disarmed", alarm_hit, 0);
    end
    en = 1'b0;
    chk("alm_dis_time", {hr_bcd, min_bcd, sec_bcd}, {6'h07, 7'h00, 7'h00});
    alm_arm = 1'b1;
    set_time(6'h06, 7'h00, 7'h00);
    alm_hr = 6'h24; alm_min = 7'h00; alm_we = 1'b1;
    step();
    alm_we = 1'b0;
    set_time(6'h07, 7'h00, 7'h00);
    chk("alm_on_set", alarm_hit, 1);
    step();
    chk("alm_set_off", alarm_hit, 0);

    set_time(6'h05, 7'h00, 7'h00);
    en = 1'b1;
    step(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frz_tick", tick, 0);
    end
    chk("frz_time", {hr_bcd, min_bcd, sec_bcd}, {6'h05, 7'h00, 7'h00});
    en = 1'b1;
    step();
    chk("frz_resume0", tick, 0);
    step();
    chk("frz_resume1", {tick, hr_bcd, min_bcd, sec_bcd}, {1'b1, 6'h05, 7'h00, 7'h01});
    step(2);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("mid_rst", {tick, hr_bcd, min_bcd, sec_bcd}, {1'b0, 6'h00, 7'h00, 7'h00});
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("rst_restart", tick, (i == 4));
    end
    chk("rst_sec", sec_bcd, 7'h01);

    en1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("div1_tick", tick1, 1);
    end
    chk("div1_sec", sec1, 7'h05);
    en1 = 1'b0;
    step();
    chk("div1_off", tick1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rtc_hms_cfg.md
Name: rtc_hms_cfg

Overview:
- Parametrised successor to the fixed 12-hour sec/min/hour timer.
- Keeps time internally as 24-hour BCD, driven by a configurable prescaler from the board clock.
- Presents time in either 12-hour (with AM/PM) or 24-hour form, selectable at run time.
- Adds a validated time-set load, a programmable alarm and a day-rollover strobe; feeds the seven-segment decoders directly.

Parameters:
- TICK_DIV, 50000000: clk_50 cycles per one-second tick; legal range ≥1.
- ALARM_EN, 1: 1 = alarm logic present; 0 = alarm_hit tied 0 and alarm registers removed.

Ports:
- clk_50  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-high (port keeps the codebase name; asserted = 1).
- en  in  1  run enable; gates prescaler and time counting.
- mode_24  in  1  display mode: 0 = 12-hour + AM/PM, 1 = 24-hour.
- set_stb  in  1  one-cycle strobe: load set_* into time.
- set_hr  in  6  BCD hour, 24-hour form; [5:4] tens, [3:0] units.
- set_min  in  7  BCD minute; [6:4] tens, [3:0] units.
- set_sec  in  7  BCD second.
- set_err  out  1  one-cycle pulse: set_stb rejected.
- alm_we  in  1  strobe: load alm_hr/alm_min into alarm registers.
- alm_hr  in  6  BCD alarm hour, 24-hour form.
- alm_min  in  7  BCD alarm minute.
- alm_arm  in  1  level: alarm armed.
- sec_bcd  out  7  displayed seconds, BCD.
- min_bcd  out  7  displayed minutes, BCD.
- hr_bcd  out  6  displayed hours, BCD, per mode_24.
- pm  out  1  1 = PM (12-hour mode only); forced 0 when mode_24 = 1.
- tick  out  1  one-cycle pulse per one-second tick.
- tc  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 transition.
- alarm_hit  out  1  one-cycle pulse on alarm match.

Behaviour:
- Reset (rst_n = 1 at a clock edge):
  - Prescaler = 0; time = 00:00:00; alarm registers = 00:00.
  - tick, tc, set_err, alarm_hit = 0.
  - Display after reset: 12:00:00 with pm = 0 (mode_24 = 0), or 00:00:00 (mode_24 = 1).
  - Reset overrides every other input, including a simultaneous set_stb.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en = 1; holds its value while en = 0.
  - tick is registered and asserts for the cycle after the count wraps.
  - TICK_DIV = 1: tick is high every cycle while en = 1.
- Time update: on each tick, sec increments.
  - sec 59 → 00 and min increments.
  - min 59 → 00 and hr increments.
  - hr 23 → 00, with tc asserted for that same tick cycle.
  - All arithmetic is BCD: units 9 → 0 with carry into tens; no binary intermediate is ever visible.
- Time set (set_stb = 1):
  - Validity: every units digit ≤ 9, sec/min tens ≤ 5, hr ≤ 23.
  - Valid: time loads on the next edge and the prescaler clears to 0, so the first tick is TICK_DIV cycles later. Load wins over a coincident tick, and that tick is dropped.
  - Invalid: time and prescaler are unchanged, and set_err pulses 1 cycle.
  - Set is accepted regardless of en.
- Display conversion: combinational from the time registers, so it follows the registers with zero latency.
  - mode_24 = 1: outputs = internal time.
  - mode_24 = 0, hr 00 → 12 AM; 01..11 → same value, AM.
  - mode_24 = 0, hr 12 → 12 PM; 13..23 → hr-12 (BCD-correct), PM.
  - Toggling mode_24 never alters stored time.
- Alarm:
  - alm_we loads alm_hr/alm_min. Invalid values are ignored silently; the registers are unchanged.
  - alarm_hit pulses when a tick (or a valid set) makes time equal alm_hr:alm_min:00 while alm_arm = 1. It fires once per match.
  - A match that already holds while time is stopped does not re-fire.
  - A set landing exactly on the alarm time does fire alarm_hit.
- Pulse outputs: tick, tc, set_err and alarm_hit are single-cycle and registered. They never stretch under back-to-back events.

Test Plan:
- Reset: TICK_DIV = 4; hold rst_n = 1 for 3 cycles with set_stb = 1 → time 00:00:00, hr_bcd = 0x12, pm = 0, all pulses 0.
- Rollover: TICK_DIV = 4, mode_24 = 1, set 23:59:58, en = 1.
  - tick every 4th cycle.
  - After 2 ticks: 00:00:00 with tc high exactly 1 cycle.
  - min/hr carries are correct at 59.
- 12-hour mapping: set hr 00, 11, 12, 13, 23 with mode_24 = 0 → hr_bcd/pm = 12/0, 11/0, 12/1, 01/1, 11/1. Toggle mode_24 → 00, 11, 12, 13, 23, pm = 0.
- Set validation: set 24:00:00, then 10:60:00, then 10:0A:00 → set_err pulses, time unchanged. Set 10:30:00 coincident with tick → 10:30:00 loaded, next tick 4 cycles later.
- Alarm: alm 07:00, arm = 1, set 06:59:59 → alarm_hit single pulse at 07:00:00. Same test with arm = 0 → no pulse. en = 0 at 07:00:00 → no repeat pulse.
- Mid-run reset and enable gating: en = 0 for 10 cycles → time and prescaler frozen. rst_n = 1 mid-count → 00:00:00 next edge, prescaler restarts from 0.
